// File: rtl/sync_nflops_edge_if.sv
// sync_nflops_edge_if
//   Bundles the per-channel level inputs and the synchronized/edge outputs
//   of sync_nflops_edge.
//   Ports (signals):
//     async_in   [NUM_CH]  asynchronous level inputs, driven by the master
//     sync_out   [NUM_CH]  synchronized (optionally filtered) levels
//     rise_pulse [NUM_CH]  one-cycle strobe on a 0->1 change of sync_out
//     fall_pulse [NUM_CH]  one-cycle strobe on a 1->0 change of sync_out
//     any_edge             OR of every rise and fall strobe
//   Modports: master (drives async_in, observes results), slave (the
//   synchronizer itself).
interface sync_nflops_edge_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0] async_in;
  logic [NUM_CH-1:0] sync_out;
  logic [NUM_CH-1:0] rise_pulse;
  logic [NUM_CH-1:0] fall_pulse;
  logic              any_edge;

  modport master (
    output async_in,
    input  sync_out,
    input  rise_pulse,
    input  fall_pulse,
    input  any_edge
  );

  modport slave (
    input  async_in,
    output sync_out,
    output rise_pulse,
    output fall_pulse,
    output any_edge
  );
endinterface

// File: rtl/sync_nflops_edge.sv
// sync_nflops_edge
//   Multi-channel flop-chain synchronizer with registered rise/fall edge
//   strobes. Each of NUM_CH independent single-bit channels is passed
//   through STAGES flops; the last stage is the raw synchronized level.
//   Optional build macro SYNC_FILTER_EN inserts a per-channel glitch filter
//   between raw and sync_out that only follows raw after it has differed
//   from the filtered level for FILT_CNT consecutive cycles.
//   Ports:
//     clk  rising-edge clock for all state
//     rst  synchronous active-high reset; all state loads RST_VAL
//     bus  sync_nflops_edge_if.slave (async_in, sync_out, rise_pulse,
//          fall_pulse, any_edge); the interface NUM_CH must equal NUM_CH
//   Parameters: NUM_CH (>=1), STAGES (>=2), FILT_CNT (>=1), RST_VAL.
module sync_nflops_edge #(
  parameter int                NUM_CH   = 4,
  parameter int                STAGES   = 2,
  parameter int                FILT_CNT = 3,
  parameter logic [NUM_CH-1:0] RST_VAL  = '0
) (
  input  logic                clk,
  input  logic                rst,
  sync_nflops_edge_if.slave   bus
);

  // A single flop is not a synchronizer; reject it at elaboration.
  if (STAGES < 2) begin : g_bad_stages
    $error("sync_nflops_edge: STAGES must be >= 2");
  end

  if (FILT_CNT < 1) begin : g_bad_filt
    $error("sync_nflops_edge: FILT_CNT must be >= 1");
  end

  logic [NUM_CH-1:0] chain [STAGES];
  logic [NUM_CH-1:0] raw;
  logic [NUM_CH-1:0] level;
  logic [NUM_CH-1:0] prev;

  // Synchronizer chain: stage 0 samples the asynchronous inputs, each later
  // stage copies its predecessor. Reset flushes anything still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        chain[i] <= RST_VAL;
      end
    end else begin
      chain[0] <= bus.async_in;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign raw = chain[STAGES-1];

`ifdef SYNC_FILTER_EN
  // One spare bit so FILT_CNT-1 is always representable, even for FILT_CNT=1.
  localparam int             CW        = $clog2(FILT_CNT) + 1;
  localparam logic [CW-1:0]  FILT_LAST = CW'(FILT_CNT - 1);

  logic [CW-1:0]     cnt [NUM_CH];
  logic [NUM_CH-1:0] filt;

  // Glitch filter: the counter tracks how many consecutive cycles raw has
  // disagreed with filt; any agreement restarts it, and the FILT_CNT-th
  // disagreeing cycle commits raw into filt.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt <= RST_VAL;
      for (int c = 0; c < NUM_CH; c++) begin
        cnt[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (raw[c] == filt[c]) begin
          cnt[c] <= '0;
        end else if (cnt[c] == FILT_LAST) begin
          filt[c] <= raw[c];
          cnt[c]  <= '0;
        end else begin
          cnt[c] <= cnt[c] + CW'(1);
        end
      end
    end
  end

  assign level = filt;
`else
  assign level = raw;
`endif

  // Previous-cycle copy of the output level. Resetting it to RST_VAL together
  // with the chain keeps reset itself from looking like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= RST_VAL;
    end else begin
      prev <= level;
    end
  end

  // Both operands are flop outputs, so there is no path from async_in to the
  // strobes, and a channel can never rise and fall in the same cycle.
  assign bus.sync_out   = level;
  assign bus.rise_pulse = level & ~prev;
  assign bus.fall_pulse = ~level & prev;
  assign bus.any_edge   = |(bus.rise_pulse | bus.fall_pulse);

endmodule

// File: doc/sync_nflops_edge.md
SYNC_NFLOPS_EDGE -- requirements
Module: sync_nflops_edge

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent single-bit channels (>=1).
REQ-002 SHALL have parameter STAGES, default 2, synchronizer flop depth per channel (>=2; values <2 are an elaboration error).
REQ-003 SHALL have parameter FILT_CNT, default 3, consecutive-cycle stability count for the glitch filter (>=1).
REQ-004 SHALL have parameter RST_VAL, default all-zeros, NUM_CH-bit reset value for every channel.
REQ-005 clk  input  1  clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 async_in  input  NUM_CH  asynchronous level inputs, one per channel.
REQ-008 sync_out  output  NUM_CH  synchronized (and, if enabled, filtered) levels.
REQ-009 rise_pulse  output  NUM_CH  one-cycle strobe per channel on a 0->1 change of sync_out.
REQ-010 fall_pulse  output  NUM_CH  one-cycle strobe per channel on a 1->0 change of sync_out.
REQ-011 any_edge  output  1  OR of all bits of rise_pulse and fall_pulse.

Function
REQ-012 Each channel SHALL pass async_in through a chain of STAGES flops; the last stage is the raw synchronized value (raw).
REQ-013 Without filter: sync_out = raw; a level sampled at edge E SHALL appear on sync_out after edge E+STAGES-1.
REQ-014 A prev register per channel SHALL hold sync_out from the previous cycle.
REQ-015 rise_pulse = sync_out & ~prev and fall_pulse = ~sync_out & prev, decoded from registers only, high exactly one cycle per change.
REQ-016 Channels SHALL be fully independent; simultaneous changes on several channels SHALL produce simultaneous pulses on each.
REQ-017 rise_pulse and fall_pulse of the same channel SHALL never be high together.
REQ-018 No combinational path SHALL exist from async_in to any output.

Reset
REQ-019 While rst=1 at a rising edge, all sync stages, prev, sync_out and filter state SHALL load RST_VAL (filter counters 0).
REQ-020 During reset and in the first cycle after release, rise_pulse, fall_pulse and any_edge SHALL be 0.
REQ-021 rst asserted mid-operation (filter count in progress, edge pending in the chain) SHALL discard all pending state; no pulse is generated by the reset itself.

Configuration
REQ-022 Macro SYNC_FILTER_EN SHALL compile in a per-channel glitch filter between raw and sync_out.
REQ-023 With SYNC_FILTER_EN: per channel a counter of width clog2(FILT_CNT)+1 and a filt register; sync_out = filt.
REQ-024 Filter rule per edge: raw==filt -> cnt<=0; raw!=filt and cnt==FILT_CNT-1 -> filt<=raw, cnt<=0; otherwise cnt<=cnt+1.
REQ-025 With SYNC_FILTER_EN, a change persisting in raw from edge E+STAGES-1 SHALL reach sync_out after edge E+STAGES-1+FILT_CNT; a raw excursion shorter than FILT_CNT cycles SHALL not change sync_out.
REQ-026 Without SYNC_FILTER_EN: no counter or filt logic exists, FILT_CNT is ignored, timing per REQ-013.

Verification (NUM_CH=4, STAGES=3, FILT_CNT=3, RST_VAL=4'b0000 unless stated)
REQ-027 Hold rst=1, async_in=4'hF -> sync_out=4'h0, no pulses; release rst -> sync_out=4'hF after 3 edges (no filter), rise_pulse=4'hF one cycle, any_edge=1 one cycle.
REQ-028 Filter off, async_in[0] 0->1 sampled at edge E -> sync_out[0]=1 after edge E+2; rise_pulse=4'b0001 for exactly one cycle.
REQ-029 Filter off, async_in 4'hF->4'hA -> fall_pulse=4'b0101 one cycle, rise_pulse=0, sync_out=4'hA.
REQ-030 SYNC_FILTER_EN, async_in[1] high for 2 cycles then low -> sync_out stays 4'h0, no pulses; high for 3+ cycles -> sync_out[1]=1 after edge E+5, rise_pulse[1] one cycle.
REQ-031 SYNC_FILTER_EN, rst pulsed 1 cycle while ch2 counter=2 -> counter 0, sync_out=RST_VAL, no pulse; 3 more stable cycles needed after chain refills.
REQ-032 RST_VAL=4'hF, STAGES=2: release rst with async_in=4'hF -> no pulses; async_in->4'h0 -> fall_pulse=4'hF one cycle after edge E+1.
